mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-ported mmu between two requesters: the instruction-fetch port (I) and the load/store data port (D) of the pipelined processor.
- Sequences each access: drives mmu chipSel/addr/write, drives the shared data bus for writes, and waits for mmu ready.
- Returns read data and a one-cycle ack to the winning requester.
- Round-robin on contention; a timeout watchdog flags accesses where ready never arrives.

Parameters:
- AW, 8, address width (mmu address bus).
- DW, 32, data width (mmu data bus).
- TIMEOUT, 16, BUSY cycles without mem_ready before an access is aborted with error.
- CW, 5, timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, posedge.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  fetch request, level; held until i_ack.
- i_addr  in  AW  fetch address.
- i_rdata  out  DW  fetch read data; valid while i_ack=1, held until next I ack.
- i_ack  out  1  one-cycle completion pulse.
- i_err  out  1  qualifies i_ack: access timed out.
- d_req  in  1  data request, level; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_rdata  out  DW  load data; valid while d_ack=1.
- d_ack  out  1  one-cycle completion pulse.
- d_err  out  1  qualifies d_ack: access timed out.
- mem_cs  out  1  mmu chipSel.
- mem_addr  out  AW  mmu address.
- mem_write  out  1  mmu write.
- mem_dat  inout  DW  mmu data bus.
  - Arbiter drives it only when mem_cs=1, mem_write=1 and grant=D.
  - Otherwise high-Z.
- mem_ready  in  1  mmu access complete, sampled at posedge.

Behaviour:
- Reset values: state IDLE, all outputs 0, mem_dat high-Z, last_grant=I, counter 0. Reset takes effect immediately mid-access.
- States: IDLE, BUSY, RELEASE.
- IDLE, at posedge:
  - Arbitrate among sampled requests.
  - Only one request: grant it.
  - Both requests: grant the port opposite last_grant, so D wins the first tie after reset.
  - Latch grant, addr, we, wdata into registers; go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - mem_cs=1; mem_addr and mem_write come from the latched registers.
  - mem_write=0 for I grants.
  - Counter increments each posedge.
  - On the posedge where mem_ready=1:
    - Capture mem_dat into the granted port's rdata on reads.
    - Write grants leave rdata unchanged.
    - Go to RELEASE; set the granted port's ack=1, err=0.
    - Update last_grant.
  - If the counter reaches TIMEOUT-1 with mem_ready still 0:
    - Go to RELEASE; ack=1, err=1.
    - Granted rdata = 0.
- RELEASE:
  - mem_cs=0, mem_write=0, bus high-Z, ack high for exactly this cycle.
  - Next posedge: go to IDLE, clear ack/err.
  - Requests are not arbitrated in RELEASE. This gives the requester one edge to drop req and gives the mmu one cycle with chipSel low between accesses.
- Latency: request sampled at edge N. The mmu sees cs from N; with mmu ready at edge N+k, ack is high during cycle N+k to N+k+1. Minimum turnaround between accesses is 2 cycles (RELEASE, IDLE).
- At most one ack is high in any cycle.
- Request inputs are ignored outside IDLE. A losing requester simply stays pending.
- mem_ready seen in IDLE or RELEASE is ignored.
- mem_ready and timeout on the same edge: ready wins, err=0.
- A req that drops during BUSY is a protocol violation; the access still completes and acks.
- After an I grant, a pending D always gets the next grant, and vice versa. Neither port starves.

Decomposition:
- Shared package mem_pkg holds:
  - State encoding: IDLE=2'd0, BUSY=2'd1, RELEASE=2'd2.
  - Grant encoding: GRANT_I=0, GRANT_D=1.
  - Default AW/DW.
- One sub-module, mem_timeout_ctr: loadable up-counter with clear and terminal-count flag, used by BUSY.
- The tri-state driver stays in the top level.

Test Plan:
1. D write only: d_req=1, d_we=1, d_addr=1, d_wdata=15; mmu ready after 2 posedges -> mem_dat=15 while cs=1; d_ack one cycle, d_err=0; cs low in RELEASE.
2. D read-back: d_addr=1, d_we=0 -> d_rdata=15 during d_ack; mem_dat never driven by arbiter; i_ack stays 0.
3. Tie after reset: i_req and d_req both asserted on the same edge, addresses 2 and 1 -> D granted first.
   - d_ack, then I granted at the following IDLE edge.
   - i_rdata = mmu content of address 2 (14 after a prior write).
4. Back-to-back contention: both reqs continuously reasserted after each ack for 4 transactions -> grant sequence D, I, D, I; no ack overlap.
5. Timeout: mem_ready tied 0, i_req with i_addr=34 -> after TIMEOUT=16 BUSY cycles, i_ack=1, i_err=1, i_rdata=0; return to IDLE.
6. Reset mid-BUSY during a D write -> mem_cs=0 and mem_dat high-Z immediately; no ack pulses; the next request after reset is served normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and defaults for the mmu arbiter
package mem_pkg;

   localparam int AW_DEF = 8;
   localparam int DW_DEF = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

   // On a tie the port that did not win last time goes next, so neither side starves.
   function automatic grant_t pick_grant(input logic req_i, input logic req_d, input grant_t last);
      if (req_i && req_d)
         return (last == GRANT_I) ? GRANT_D : GRANT_I;
      else if (req_d)
         return GRANT_D;
      else
         return GRANT_I;
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - loadable up-counter with clear and terminal-count flag
module mem_timeout_ctr
   import mem_pkg::*;
#(
   parameter int CW      = 5,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          en,
   output logic          tc
);

   logic [CW-1:0] count;

   // Load wins over clear so a fresh grant always starts from load_val.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (clr)
         count <= '0;
      else if (en)
         count <= count + CW'(1);
   end

   assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing the mmu between fetch and data ports
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = 16,
   parameter int CW      = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_rdata,
   output logic          i_ack,
   output logic          i_err,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   output logic          d_err,
   output logic          mem_cs,
   output logic [AW-1:0] mem_addr,
   output logic          mem_write,
   inout  wire  [DW-1:0] mem_dat,
   input  logic          mem_ready
);

   state_t        state, next_state;
   grant_t        grant_q, last_grant, grant_sel;
   logic [AW-1:0] addr_q;
   logic          we_q;
   logic [DW-1:0] wdata_q;
   logic          err_q;
   logic          start, done_ok, done_to;
   logic          drive_en, tc;

   mem_timeout_ctr #(.CW(CW), .TIMEOUT(TIMEOUT)) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clr      (state != BUSY),
      .load     (start),
      .load_val ('0),
      .en       (state == BUSY),
      .tc       (tc)
   );

   // State register; reset drops chipSel and the bus driver immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next state, arbitration decision and mmu strobes.
   always_comb begin
      next_state = state;
      grant_sel  = pick_grant(i_req, d_req, last_grant);
      start      = 1'b0;
      done_ok    = 1'b0;
      done_to    = 1'b0;
      mem_cs     = 1'b0;
      mem_write  = 1'b0;
      drive_en   = 1'b0;
      case (state)
         IDLE: begin
            if (i_req || d_req) begin
               start      = 1'b1;
               next_state = BUSY;
            end
         end
         BUSY: begin
            mem_cs    = 1'b1;
            mem_write = we_q;
            drive_en  = we_q && (grant_q == GRANT_D);
            if (mem_ready) begin
               done_ok    = 1'b1;
               next_state = RELEASE;
            end else if (tc) begin
               done_to    = 1'b1;
               next_state = RELEASE;
            end
         end
         RELEASE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Latch the winning request and capture completion results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_q    <= GRANT_I;
         last_grant <= GRANT_I;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         if (start) begin
            grant_q <= grant_sel;
            addr_q  <= (grant_sel == GRANT_D) ? d_addr : i_addr;
            we_q    <= (grant_sel == GRANT_D) && d_we;
            wdata_q <= d_wdata;
         end
         if (done_ok || done_to) begin
            last_grant <= grant_q;
            err_q      <= done_to;
         end
         if (done_ok && !we_q) begin
            if (grant_q == GRANT_I)
               i_rdata <= mem_dat;
            else
               d_rdata <= mem_dat;
         end
         if (done_to) begin
            if (grant_q == GRANT_I)
               i_rdata <= '0;
            else
               d_rdata <= '0;
         end
      end
   end

   assign mem_addr = addr_q;
   assign mem_dat  = drive_en ? wdata_q : {DW{1'bz}};
   assign i_ack    = (state == RELEASE) && (grant_q == GRANT_I);
   assign d_ack    = (state == RELEASE) && (grant_q == GRANT_D);
   assign i_err    = i_ack && err_q;
   assign d_err    = d_ack && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter with an mmu model
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic [7:0]  i_addr = '0;
   logic [31:0] i_rdata;
   logic        i_ack, i_err;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [7:0]  d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_ack, d_err;
   logic        mem_cs, mem_write, mem_ready;
   logic [7:0]  mem_addr;
   wire  [31:0] mem_dat;

   int vectors = 0;
   int miscompares = 0;

   // mmu model: ready after lat BUSY cycles when enabled, drives 0 whenever it is not supplying read data
   logic [31:0] mem [0:255];
   int          cyc = 0;
   int          lat = 1;
   bit          rdy_en = 1'b1;

   assign mem_ready = mem_cs && rdy_en && (cyc == lat - 1);
   assign mem_dat   = (mem_cs && mem_write) ? 32'bz : (mem_cs ? mem[mem_addr] : 32'h0);

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_cs) begin
         cyc <= cyc + 1;
         if (mem_write && mem_ready)
            mem[mem_addr] <= mem_dat;
      end else begin
         cyc <= 0;
      end
   end

   mem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_rdata   (i_rdata),
      .i_ack     (i_ack),
      .i_err     (i_err),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_ack     (d_ack),
      .d_err     (d_err),
      .mem_cs    (mem_cs),
      .mem_addr  (mem_addr),
      .mem_write (mem_write),
      .mem_dat   (mem_dat),
      .mem_ready (mem_ready)
   );

   typedef struct {
      bit          port;   // 0 = I, 1 = D
      bit          we;
      logic [7:0]  addr;
      logic [31:0] wd;
      int          lat;
      bit          rdy;
      bit          err;
      logic [31:0] rd;     // granted port rdata expected at ack
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic access(input vec_t v);
      int n;
      bit seen;
      bit bus_ok;
      @(negedge clk);
      lat     = v.lat;
      rdy_en  = v.rdy;
      i_addr  = v.addr;
      d_addr  = v.addr;
      d_we    = v.we;
      d_wdata = v.wd;
      if (v.port) d_req = 1'b1;
      else        i_req = 1'b1;
      n = 0;
      seen = 1'b0;
      bus_ok = 1'b1;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (i_ack && d_ack) bus_ok = 1'b0;
         if (mem_cs) begin
            if (mem_addr !== v.addr || mem_write !== (v.port && v.we)) bus_ok = 1'b0;
            if (mem_write && mem_dat !== v.wd) bus_ok = 1'b0;
         end else if (mem_dat !== 32'h0) begin
            bus_ok = 1'b0;
         end
         if (i_ack || d_ack) seen = 1'b1;
      end
      i_req = 1'b0;
      d_req = 1'b0;
      chk("ack_port", {30'b0, i_ack, d_ack}, v.port ? 32'd1 : 32'd2);
      chk("ack_cycle", n, v.lat + 1);
      chk("err", v.port ? d_err : i_err, {31'b0, v.err});
      chk("rdata", v.port ? d_rdata : i_rdata, v.rd);
      chk("bus", {31'b0, bus_ok}, 32'd1);
      @(negedge clk);
      chk("back_idle", {29'b0, mem_cs, i_ack, d_ack}, 32'd0);
      chk("idle_bus", mem_dat, 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int n;
      int nack;
      bit overlap;
      bit exp_d;
      vecs[0] = '{1'b1, 1'b1, 8'd1,  32'd15,         2,  1'b1, 1'b0, 32'd0};
      vecs[1] = '{1'b1, 1'b0, 8'd1,  32'h0000_0f0f,  1,  1'b1, 1'b0, 32'd15};
      vecs[2] = '{1'b1, 1'b1, 8'd2,  32'd14,         3,  1'b1, 1'b0, 32'd15};
      vecs[3] = '{1'b0, 1'b0, 8'd2,  32'h0,          2,  1'b1, 1'b0, 32'd14};
      vecs[4] = '{1'b0, 1'b0, 8'd1,  32'h0,          15, 1'b1, 1'b0, 32'd15};
      vecs[5] = '{1'b1, 1'b0, 8'd2,  32'h0000_0f0f,  16, 1'b1, 1'b0, 32'd14};
      vecs[6] = '{1'b0, 1'b0, 8'd34, 32'h0,          16, 1'b0, 1'b1, 32'd0};
      vecs[7] = '{1'b1, 1'b1, 8'd3,  32'hcafe_f00d,  16, 1'b0, 1'b1, 32'd0};
      vecs[8] = '{1'b1, 1'b1, 8'd3,  32'hcafe_f00d,  1,  1'b1, 1'b0, 32'd0};
      vecs[9] = '{1'b1, 1'b0, 8'd3,  32'h0000_0f0f,  2,  1'b1, 1'b0, 32'hcafe_f00d};

      // reset state
      @(negedge clk);
      chk("rst_ctrl", {26'b0, mem_cs, mem_write, i_ack, i_err, d_ack, d_err}, 32'd0);
      chk("rst_addr", {24'b0, mem_addr}, 32'd0);
      chk("rst_i_rdata", i_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_bus", mem_dat, 32'h0);
      do_reset();

      for (int i = 0; i < 10; i++)
         access(vecs[i]);

      // tie straight after reset then sustained contention: D, I, D, I
      do_reset();
      @(negedge clk);
      lat = 1;
      rdy_en = 1'b1;
      i_addr = 8'd2;
      d_addr = 8'd1;
      d_we = 1'b0;
      d_wdata = 32'h0000_0f0f;
      i_req = 1'b1;
      d_req = 1'b1;
      n = 0;
      nack = 0;
      overlap = 1'b0;
      while (nack < 4 && n < 60) begin
         @(negedge clk);
         n++;
         if (i_ack && d_ack) overlap = 1'b1;
         if (i_ack || d_ack) begin
            exp_d = (nack % 2) == 0;
            chk("tie_port", {31'b0, d_ack}, {31'b0, exp_d});
            chk("tie_cycle", n, 2 + 3 * nack);
            if (nack == 0) chk("tie_d_rdata", d_rdata, 32'd15);
            if (nack == 1) chk("tie_i_rdata", i_rdata, 32'd14);
            nack++;
         end
      end
      i_req = 1'b0;
      d_req = 1'b0;
      chk("tie_acks", nack, 4);
      chk("tie_overlap", {31'b0, overlap}, 32'd0);

      // reset in the middle of a D write
      @(negedge clk);
      @(negedge clk);
      rdy_en = 1'b0;
      d_addr = 8'd5;
      d_we = 1'b1;
      d_wdata = 32'hdead_beef;
      d_req = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_busy_drive", {mem_cs, mem_dat[30:0]}, {1'b1, 31'h5ead_beef});
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_ctrl", {30'b0, mem_cs, mem_write}, 32'd0);
      chk("mid_rst_bus", mem_dat, 32'h0);
      chk("mid_rst_addr", {24'b0, mem_addr}, 32'd0);
      d_req = 1'b0;
      d_we = 1'b0;
      overlap = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (i_ack || d_ack || mem_cs) overlap = 1'b1;
      end
      chk("mid_rst_quiet", {31'b0, overlap}, 32'd0);
      rst = 1'b0;
      access('{1'b0, 1'b0, 8'd1, 32'h0, 2, 1'b1, 1'b0, 32'd15});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
